// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline freeze/flush sequencer.
//   state_t      : SRAM access FSM states (RUN, WAIT)
//   TIMEOUT_DEF  : default number of WAIT cycles tolerated before an abort
package pipe_hazard_ctrl_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam int TIMEOUT_DEF = 16;

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the stall/flush statistics.
// Ports:
//   clk, rst : clock, synchronous active-high reset (zeroes the count)
//   inc      : add one this cycle unless already all-ones
//   clr      : synchronous clear, wins over inc
//   count    : current value
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count_q <= '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central freeze/flush sequencer for the five-stage pipeline. Arbitrates the
// MEM-stage SRAM wait, a taken branch in EXE and a data hazard, and drives
// the stage-register freeze/flush controls (all Mealy, sampled at next edge).
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   hazard          : data hazard from the hazard unit
//   branch_taken    : taken branch in EXE
//   mem_req         : MEM stage wants an SRAM access
//   sram_ack        : SRAM controller completes the access this cycle
//   clr_stats       : clear both statistics counters
//   sram_req        : request to the SRAM controller
//   freeze_front    : freeze PC and IF/ID
//   freeze_back     : freeze ID/EX, EX/MEM, MEM/WB
//   flush_if_id     : flush IF/ID
//   flush_id_exe    : flush ID/EX
//   timeout_err     : sticky, an SRAM access was aborted (cleared by rst only)
//   stall_cnt       : saturating count of memory-stall cycles
//   flush_cnt       : saturating count of branch-flush cycles
//   state_dbg       : FSM state, 1 = WAIT
//
// SRAM handshake: sram_req is raised with mem_req and then held at 1 every
// cycle until a cycle where sram_ack=1 (access completes in that cycle) or
// the timeout abort cycle (sram_req drops to 0 in that cycle). sram_ack is
// only meaningful while sram_req=1.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int TO_W    = 5,
  parameter int STALL_W = 32,
  parameter int FLUSH_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hazard,
  input  logic               branch_taken,
  input  logic               mem_req,
  input  logic               sram_ack,
  input  logic               clr_stats,
  output logic               sram_req,
  output logic               freeze_front,
  output logic               freeze_back,
  output logic               flush_if_id,
  output logic               flush_id_exe,
  output logic               timeout_err,
  output logic [STALL_W-1:0] stall_cnt,
  output logic [FLUSH_W-1:0] flush_cnt,
  output logic               state_dbg
);

  state_t          state_q, state_d;
  logic [TO_W-1:0] wait_cnt_q, wait_cnt_d;
  logic            timeout_err_q;
  logic            at_limit;
  logic            abort;
  logic            mem_stall;

  assign at_limit = (wait_cnt_q == TO_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      if (abort) begin
        timeout_err_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    abort        = 1'b0;
    mem_stall    = 1'b0;
    sram_req     = 1'b0;
    freeze_front = 1'b0;
    freeze_back  = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_exe = 1'b0;

    case (state_q)
      RUN: begin
        sram_req  = mem_req;
        mem_stall = mem_req & ~sram_ack;
        if (mem_req && !sram_ack) begin
          state_d    = WAIT;
          wait_cnt_d = '0;
        end
      end
      WAIT: begin
        // mem_req is ignored here: the MEM stage is frozen, so the access
        // is finished by an ack or by the timeout only.
        sram_req  = sram_ack | ~at_limit;
        mem_stall = ~sram_ack & ~at_limit;
        if (sram_ack) begin
          state_d = RUN;
        end else if (at_limit) begin
          state_d = RUN;
          abort   = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase

    // Memory stall outranks branch, branch outranks hazard. A branch
    // squashes the hazard-causing instruction, so the front end keeps going.
    freeze_back  = mem_stall;
    freeze_front = mem_stall | (hazard & ~branch_taken);
    flush_if_id  = branch_taken & ~mem_stall;
    flush_id_exe = (branch_taken | hazard) & ~mem_stall;

    if (rst) begin
      sram_req     = 1'b0;
      freeze_front = 1'b0;
      freeze_back  = 1'b0;
      flush_if_id  = 1'b0;
      flush_id_exe = 1'b0;
      mem_stall    = 1'b0;
      abort        = 1'b0;
    end
  end

  sat_counter #(.W(STALL_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (mem_stall),
    .clr   (clr_stats),
    .count (stall_cnt)
  );

  sat_counter #(.W(FLUSH_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_if_id),
    .clr   (clr_stats),
    .count (flush_cnt)
  );

  assign timeout_err = timeout_err_q;
  assign state_dbg   = (state_q == WAIT);

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  localparam int TIMEOUT   = 16;
  localparam int TO_W      = 5;
  localparam int STALL_W   = 6;
  localparam int FLUSH_W   = 4;
  localparam int STALL_MAX = (1 << STALL_W) - 1;
  localparam int FLUSH_MAX = (1 << FLUSH_W) - 1;

  // ---------------- clock / reset block ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst = 1'b1;
  logic               hazard = 1'b0;
  logic               branch_taken = 1'b0;
  logic               mem_req = 1'b0;
  logic               sram_ack = 1'b0;
  logic               clr_stats = 1'b0;
  logic               sram_req;
  logic               freeze_front;
  logic               freeze_back;
  logic               flush_if_id;
  logic               flush_id_exe;
  logic               timeout_err;
  logic [STALL_W-1:0] stall_cnt;
  logic [FLUSH_W-1:0] flush_cnt;
  logic               state_dbg;

  pipe_hazard_ctrl #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W),
    .STALL_W (STALL_W),
    .FLUSH_W (FLUSH_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .hazard       (hazard),
    .branch_taken (branch_taken),
    .mem_req      (mem_req),
    .sram_ack     (sram_ack),
    .clr_stats    (clr_stats),
    .sram_req     (sram_req),
    .freeze_front (freeze_front),
    .freeze_back  (freeze_back),
    .flush_if_id  (flush_if_id),
    .flush_id_exe (flush_id_exe),
    .timeout_err  (timeout_err),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt),
    .state_dbg    (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: an access is "outstanding" after its first stalled
  // cycle; m_waited counts stall cycles spent on it so far. The abort comes
  // on the cycle after TIMEOUT stall cycles have been spent.
  bit m_busy   = 1'b0;
  int m_waited = 0;
  bit m_terr   = 1'b0;
  int m_stall  = 0;
  int m_flush  = 0;

  // ---------------- driver ----------------
  task automatic step(input bit r, input bit h, input bit b, input bit mr,
                      input bit ack, input bit clr);
    bit e_req, e_stall, e_abort, e_ff, e_fb, e_fi, e_fe;
    bit n_busy;
    int n_waited;
    @(negedge clk);
    rst          = r;
    hazard       = h;
    branch_taken = b;
    mem_req      = mr;
    sram_ack     = ack;
    clr_stats    = clr;
    #1;
    e_abort  = 1'b0;
    n_busy   = m_busy;
    n_waited = m_waited;
    if (!m_busy) begin
      e_req   = mr;
      e_stall = mr && !ack;
      if (e_stall) begin
        n_busy   = 1'b1;
        n_waited = 1;
      end
    end else if (ack) begin
      e_req   = 1'b1;
      e_stall = 1'b0;
      n_busy  = 1'b0;
    end else if (m_waited >= TIMEOUT) begin
      e_req   = 1'b0;
      e_stall = 1'b0;
      e_abort = 1'b1;
      n_busy  = 1'b0;
    end else begin
      e_req    = 1'b1;
      e_stall  = 1'b1;
      n_waited = m_waited + 1;
    end
    e_fb = e_stall;
    e_ff = e_stall || (h && !b);
    e_fi = b && !e_stall;
    e_fe = (b || h) && !e_stall;
    if (r) begin
      {e_req, e_ff, e_fb, e_fi, e_fe} = 5'b0;
    end
    exp_q.push_back({27'd0, e_req, e_ff, e_fb, e_fi, e_fe});
    check_val("comb_outs", {27'd0, sram_req, freeze_front, freeze_back,
                            flush_if_id, flush_id_exe}, exp_q.pop_front());
    check_val("state", {31'd0, state_dbg}, {31'd0, m_busy});
    check_val("timeout_err", {31'd0, timeout_err}, {31'd0, m_terr});
    check_val("stall_cnt", 32'(stall_cnt), 32'(m_stall));
    check_val("flush_cnt", 32'(flush_cnt), 32'(m_flush));
    @(posedge clk);
    if (r) begin
      m_busy   = 1'b0;
      m_waited = 0;
      m_terr   = 1'b0;
      m_stall  = 0;
      m_flush  = 0;
    end else begin
      m_busy   = n_busy;
      m_waited = n_waited;
      if (e_abort) m_terr = 1'b1;
      if (clr) begin
        m_stall = 0;
        m_flush = 0;
      end else begin
        if (e_stall && m_stall < STALL_MAX) m_stall++;
        if (e_fi && m_flush < FLUSH_MAX) m_flush++;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    step(1, 1, 1, 1, 1, 0);
    step(1, 0, 0, 0, 0, 0);

    // zero-wait access
    step(0, 0, 0, 1, 1, 0);
    idle(1);

    // ack after three stall cycles
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 1, 0);
    idle(1);
    check_val("stall_after_3", 32'(stall_cnt), 32'd3);

    // timeout with no ack
    for (int i = 0; i < TIMEOUT + 1; i++) step(0, 0, 0, 1, 0, 0);
    idle(2);
    check_val("terr_after_abort", {31'd0, timeout_err}, 32'd1);
    check_val("stall_after_to", 32'(stall_cnt), 32'd19);

    // hazard, then branch + hazard
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);

    // branch while stalled, mem_req dropping mid-wait
    step(0, 0, 1, 1, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 1, 0);
    idle(1);

    // reset in the middle of a WAIT
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 1, 0, 0);
    idle(2);

    // drive stall_cnt into saturation, then clear alongside an increment
    for (int i = 0; i < 90; i++) step(0, 0, 0, 1, 0, 0);
    check_val("stall_sat", 32'(stall_cnt), 32'(STALL_MAX));
    step(0, 0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 1, 0, 0, 0);
    check_val("flush_sat", 32'(flush_cnt), 32'(FLUSH_MAX));
    step(0, 0, 1, 0, 0, 1);
    idle(1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 1) == 0),
           ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 63) == 0));
    end

    // ---------------- final report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central freeze/flush sequencer for the five-stage ARM pipeline.
- Drives the freeze and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB stage registers and the PC.
- Arbitrates three causes of disruption: the SRAM access wait from the MEM stage, a taken branch from EXE, and a data hazard from the hazard unit.
- Contains the SRAM request/acknowledge FSM with a timeout, plus saturating stall and flush statistics counters.

Parameters:
- TIMEOUT, 16: maximum WAIT cycles without sram_ack before the access is aborted; must be ≥2.
- TO_W, 5: width of the internal wait counter; must satisfy 2^TO_W > TIMEOUT.
- STALL_W, 32: width of stall_cnt.
- FLUSH_W, 16: width of flush_cnt.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- hazard  in  1  data hazard from the hazard unit (combinational)
- branch_taken  in  1  B from the ID/EX register output (EXE stage)
- mem_req  in  1  MEM stage MEM_R_EN | MEM_W_EN
- sram_ack  in  1  SRAM controller has completed the current access
- clr_stats  in  1  synchronous clear of stall_cnt and flush_cnt
- sram_req  out  1  access request to the SRAM controller
- freeze_front  out  1  freeze for the PC and the IF/ID register
- freeze_back  out  1  freeze for the ID/EX, EX/MEM and MEM/WB registers
- flush_if_id  out  1  flush for the IF/ID register
- flush_id_exe  out  1  flush for the ID/EX register
- timeout_err  out  1  sticky flag: an SRAM access was aborted
- stall_cnt  out  STALL_W  cycles with mem_stall=1
- flush_cnt  out  FLUSH_W  cycles with a branch flush

Behaviour:
- Reset: one clk edge with rst=1 forces state=RUN, wait_cnt=0, timeout_err=0, stall_cnt=0, flush_cnt=0.
  - While rst=1, every combinational output is forced to 0.
  - Reset in the middle of a WAIT abandons the access without setting timeout_err.
- FSM states: RUN, WAIT.
  - RUN:
    - mem_req=0: no request.
    - mem_req=1 and sram_ack=1: zero-wait completion; stay in RUN.
    - mem_req=1 and sram_ack=0: go to WAIT with wait_cnt=0.
  - WAIT:
    - sram_ack=1: go to RUN.
    - sram_ack=0 and wait_cnt==TIMEOUT-1: abort; go to RUN and set timeout_err on the next edge.
    - Otherwise: wait_cnt increments.
- mem_stall (internal):
  - In RUN: mem_stall = mem_req & ~sram_ack.
  - In WAIT: mem_stall = ~sram_ack & ~(wait_cnt==TIMEOUT-1).
  - It is 0 on the completion cycle and on the abort cycle, so the pipeline advances in that same cycle.
- sram_req:
  - In RUN it equals mem_req.
  - In WAIT it is 1, except on the abort cycle, where it is 0.
  - It is held stable until sram_ack or abort.
- Priority of causes: memory stall > branch > hazard.
  - freeze_back = mem_stall.
  - freeze_front = mem_stall | (hazard & ~branch_taken).
  - flush_if_id = branch_taken & ~mem_stall.
  - flush_id_exe = (branch_taken | hazard) & ~mem_stall. Under a hazard this inserts a bubble while the front end holds.
- Output timing:
  - All freeze and flush outputs are Mealy (zero-latency) combinational outputs.
  - Consumers sample them at the next rising edge of clk; they must be glitch-free at that edge only.
- Counters:
  - stall_cnt increments on each cycle with mem_stall=1.
  - flush_cnt increments on each cycle with flush_if_id=1.
  - Both saturate at all-ones and do not wrap.
  - clr_stats=1 zeroes both counters and has priority over an increment in the same cycle.
- timeout_err is cleared only by rst.
- Simultaneous branch_taken and hazard: branch wins, and freeze_front=0, because the hazard-causing instruction is being squashed.
- mem_req dropping while in WAIT: ignored. The FSM still waits for sram_ack or the timeout, because the MEM stage is frozen.

Decomposition:
- Shared package: the state enum (RUN, WAIT) and the default TIMEOUT constant.
- One sub-module, sat_counter (parameter W; inputs inc and clr), instantiated twice for the statistics counters.

Test Plan:
- sram_ack held 1; mem_req pulsed for 1 cycle → sram_req=1 that cycle; freeze_back=0; state stays RUN; stall_cnt=0.
- mem_req=1; sram_ack rises 3 cycles later → freeze_front=freeze_back=1 for exactly 3 cycles, 0 on the ack cycle; stall_cnt=3; timeout_err=0.
- mem_req=1; sram_ack never rises (TIMEOUT=16) → freeze for 16 cycles; sram_req=0 on cycle 16; timeout_err=1 from cycle 17; stall_cnt=16.
- hazard=1 and branch_taken=0 for 2 cycles → freeze_front=1, flush_id_exe=1, freeze_back=0, flush_if_id=0 in both cycles. Then hazard=branch_taken=1 → flush_if_id=flush_id_exe=1, freeze_front=0; flush_cnt=1.
- branch_taken=1 during a WAIT stall → both flush outputs stay 0 until the ack cycle, then assert; flush_cnt increments once.
- rst=1 at WAIT cycle 5 → next cycle state=RUN, sram_req=0, counters=0, timeout_err=0. Also force stall_cnt to all-ones and stall once more → value unchanged. Assert clr_stats together with an increment → 0.
